// File: rtl/fifo_arb_pkg.sv
// Shared types and helpers for the FIFO write-port round-robin arbiter.
// The optional burst lock is enabled with the FIFO_ARB_BURST_LOCK_EN macro.
package fifo_arb_pkg;

  localparam int N_REQ_DEF  = 4;
  localparam int DATA_W_DEF = 8;
  localparam int CNT_W_DEF  = 16;

  typedef enum logic [1:0] {
    ARB   = 2'd0,
    STALL = 2'd1,
    LOCK  = 2'd2
  } arb_state_e;

  // Index width for a requester vector; never below one bit.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/fifo_wr_arbiter_rr_pick.sv
// Rotating-priority encoder: the first asserted request after rr_ptr wins,
// wrapping modulo N. Purely combinational.
module rr_pick #(
  parameter int N     = 4,
  parameter int IDX_W = 2
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] rr_ptr,
  output logic [IDX_W-1:0] sel_idx,
  output logic             sel_vld
);

  logic [IDX_W-1:0] idx;

  // Walk from farthest to nearest so the nearest asserted index is the last write.
  always_comb begin
    sel_idx = '0;
    idx     = '0;
    for (int k = N; k >= 1; k--) begin
      idx = IDX_W'((int'(rr_ptr) + k) % N);
      if (req[idx]) sel_idx = idx;
    end
    sel_vld = |req;
  end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing one FIFO write port between N_REQ producers.
// Define FIFO_ARB_BURST_LOCK_EN to add req_last and multi-beat grant locking.
module fifo_wr_arbiter
  import fifo_arb_pkg::*;
#(
  parameter int N_REQ  = N_REQ_DEF,
  parameter int DATA_W = DATA_W_DEF,
  parameter int CNT_W  = CNT_W_DEF
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [N_REQ-1:0]        req,
  input  logic [N_REQ*DATA_W-1:0] req_data,
`ifdef FIFO_ARB_BURST_LOCK_EN
  input  logic [N_REQ-1:0]        req_last,
`endif
  output logic [N_REQ-1:0]        req_ack,
  output logic                    fifo_wr_en,
  output logic [DATA_W-1:0]       fifo_wr_data,
  input  logic                    fifo_wr_ready,
  output logic                    busy,
  output logic [CNT_W-1:0]        xfer_cnt,
  output arb_state_e              dbg_state
);

  // Handshake: a requester raises req with its word and holds both until it
  // sees req_ack; a word is taken when fifo_wr_en is high while fifo_wr_ready is high.

  localparam int IDX_W = idx_w(N_REQ);

  arb_state_e       state_q, state_d;
  logic [IDX_W-1:0] rr_ptr_q, rr_ptr_d;
  logic [IDX_W-1:0] lock_idx_q, lock_idx_d;
  logic [CNT_W-1:0] xfer_cnt_q, xfer_cnt_d;

  logic [IDX_W-1:0] arb_idx, sel_idx;
  logic             arb_vld, sel_vld, fire, last_beat;
  logic [DATA_W-1:0] sel_data;

  rr_pick #(
    .N     (N_REQ),
    .IDX_W (IDX_W)
  ) u_rr_pick (
    .req     (req),
    .rr_ptr  (rr_ptr_q),
    .sel_idx (arb_idx),
    .sel_vld (arb_vld)
  );

  // Outside ARB the grant is pinned to the locked requester; others are ignored.
  always_comb begin
    if (state_q == ARB) begin
      sel_idx = arb_idx;
      sel_vld = arb_vld;
    end else begin
      sel_idx = lock_idx_q;
      sel_vld = req[lock_idx_q];
    end
    fire = sel_vld & fifo_wr_ready;
`ifdef FIFO_ARB_BURST_LOCK_EN
    last_beat = req_last[sel_idx];
`else
    last_beat = 1'b1;
`endif
  end

  always_comb begin
    sel_data = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (sel_idx == IDX_W'(i)) sel_data = req_data[i*DATA_W +: DATA_W];
    end
  end

  always_comb begin
    state_d    = state_q;
    rr_ptr_d   = rr_ptr_q;
    lock_idx_d = lock_idx_q;
    xfer_cnt_d = xfer_cnt_q;
    if (fire) begin
      xfer_cnt_d = xfer_cnt_q + CNT_W'(1);
      if (last_beat) begin
        state_d  = ARB;
        rr_ptr_d = sel_idx;
      end else begin
        state_d    = LOCK;
        lock_idx_d = sel_idx;
      end
    end else if (state_q == ARB) begin
      if (sel_vld) begin
        state_d    = STALL;
        lock_idx_d = sel_idx;
      end
    end else if (state_q == STALL) begin
      // Requester withdrew its word while stalled: abandon without a write.
      if (!sel_vld) state_d = ARB;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= ARB;
      rr_ptr_q   <= IDX_W'(N_REQ - 1);
      lock_idx_q <= '0;
      xfer_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      rr_ptr_q   <= rr_ptr_d;
      lock_idx_q <= lock_idx_d;
      xfer_cnt_q <= xfer_cnt_d;
    end
  end

  // Outputs are combinational for zero-cycle latency, forced idle while reset is high.
  always_comb begin
    req_ack      = '0;
    fifo_wr_en   = 1'b0;
    fifo_wr_data = '0;
    if (!reset) begin
      fifo_wr_en = fire;
      for (int i = 0; i < N_REQ; i++) begin
        req_ack[i] = fire && (sel_idx == IDX_W'(i));
      end
      if (sel_vld) fifo_wr_data = sel_data;
    end
  end

  assign busy      = (state_q != ARB);
  assign xfer_cnt  = xfer_cnt_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Scoreboard bench for fifo_wr_arbiter: directed scenarios plus random traffic
// checked against a queue/index reference model of the arbitration rules.
module tb_fifo_wr_arbiter;
  import fifo_arb_pkg::*;

  localparam int N  = 4;
  localparam int W  = 8;
  localparam int IW = 2;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic [N-1:0]   req;
  logic [N*W-1:0] req_data;
  logic           fifo_wr_ready;
  logic [N-1:0]   last_v;
`ifdef FIFO_ARB_BURST_LOCK_EN
  logic [N-1:0]   req_last;
`endif

  logic [N-1:0]  req_ack, ack4;
  logic          fifo_wr_en, en4;
  logic [W-1:0]  fifo_wr_data, data4;
  logic          busy, busy4;
  logic [15:0]   xfer_cnt;
  logic [3:0]    xfer_cnt4;
  arb_state_e    dbg_state, dbg4;

  fifo_wr_arbiter #(.N_REQ(N), .DATA_W(W), .CNT_W(16)) dut (
    .clk           (clk),
    .reset         (reset),
    .req           (req),
    .req_data      (req_data),
`ifdef FIFO_ARB_BURST_LOCK_EN
    .req_last      (req_last),
`endif
    .req_ack       (req_ack),
    .fifo_wr_en    (fifo_wr_en),
    .fifo_wr_data  (fifo_wr_data),
    .fifo_wr_ready (fifo_wr_ready),
    .busy          (busy),
    .xfer_cnt      (xfer_cnt),
    .dbg_state     (dbg_state)
  );

  fifo_wr_arbiter #(.N_REQ(N), .DATA_W(W), .CNT_W(4)) dut4 (
    .clk           (clk),
    .reset         (reset),
    .req           (req),
    .req_data      (req_data),
`ifdef FIFO_ARB_BURST_LOCK_EN
    .req_last      (req_last),
`endif
    .req_ack       (ack4),
    .fifo_wr_en    (en4),
    .fifo_wr_data  (data4),
    .fifo_wr_ready (fifo_wr_ready),
    .busy          (busy4),
    .xfer_cnt      (xfer_cnt4),
    .dbg_state     (dbg4)
  );

  logic [N+W-1:0] exp_q[$];
  logic [W-1:0]   data_arr[N];
  int             errors = 0;
  int             checks = 0;

  int         last_served;
  int         hold_idx;
  bit         hold_burst;
  int         cnt_model;
  int         acked_idx;
  bit         armed = 1'b0;
  logic [W-1:0] exp_show;
  logic       exp_busy;
  logic [15:0] exp_cnt;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    last_served = N - 1;
    hold_idx    = -1;
    hold_burst  = 1'b0;
    cnt_model   = 0;
    exp_q.delete();
  endtask

  task automatic drive(input logic [N-1:0] r, input logic rdy);
    req           = r;
    fifo_wr_ready = rdy;
    for (int i = 0; i < N; i++) req_data[i*W +: W] = data_arr[i];
`ifdef FIFO_ARB_BURST_LOCK_EN
    req_last = last_v;
`endif
  endtask

  // One clock: drive inputs, predict the cycle from the rules, push expected writes.
  task automatic step(input logic [N-1:0] r, input logic rdy);
    int cand;
    int p;
    bit is_last;
    logic [N-1:0] oh;
    drive(r, rdy);
    cand = -1;
    if (hold_idx >= 0) begin
      if (r[IW'(hold_idx)]) cand = hold_idx;
    end else begin
      for (int k = 1; k <= N; k++) begin
        p = (last_served + k) % N;
        if (cand < 0 && r[IW'(p)]) cand = p;
      end
    end
    exp_busy  = (hold_idx >= 0);
    exp_cnt   = cnt_model[15:0];
    exp_show  = (cand >= 0) ? data_arr[IW'(cand)] : '0;
    acked_idx = -1;
    if (cand >= 0 && rdy) begin
      oh = '0;
      oh[IW'(cand)] = 1'b1;
      exp_q.push_back({oh, data_arr[IW'(cand)]});
      cnt_model++;
      acked_idx = cand;
`ifdef FIFO_ARB_BURST_LOCK_EN
      is_last = last_v[IW'(cand)];
`else
      is_last = 1'b1;
`endif
      if (is_last) begin
        last_served = cand;
        hold_idx    = -1;
      end else begin
        hold_idx   = cand;
        hold_burst = 1'b1;
      end
    end else if (cand >= 0) begin
      if (hold_idx < 0) begin
        hold_idx   = cand;
        hold_burst = 1'b0;
      end
    end else if (hold_idx >= 0 && !hold_burst) begin
      hold_idx = -1;
    end
    armed = 1'b1;
    @(posedge clk);
    armed = 1'b0;
    chk("missing_write", exp_q.size(), 0);
    exp_q.delete();
    #1;
  endtask

  // Monitor: mid-cycle compare of everything the DUT presents.
  always @(negedge clk) begin
    logic [N+W-1:0] e;
    if (armed) begin
      chk("wr_data_view", fifo_wr_data, exp_show);
      chk("busy", busy, exp_busy);
      chk("xfer_cnt", xfer_cnt, exp_cnt);
      chk("xfer_cnt_w4", xfer_cnt4, exp_cnt[3:0]);
      if (fifo_wr_en) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_write: got data %0h ack %b expected no write at %0t",
                   fifo_wr_data, req_ack, $time);
        end else begin
          e = exp_q.pop_front();
          chk("ack", req_ack, e[N+W-1:W]);
          chk("write_data", fifo_wr_data, e[W-1:0]);
        end
      end else begin
        chk("ack_without_wr_en", req_ack, 0);
      end
    end
  end

  initial begin
    logic [N-1:0] pend;
    reset  = 1'b1;
    last_v = '1;
    for (int i = 0; i < N; i++) data_arr[i] = W'(10 + i);
    drive(4'hF, 1'b1);
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_wr_en", fifo_wr_en, 0);
    chk("rst_ack", req_ack, 0);
    chk("rst_wr_data", fifo_wr_data, 0);
    chk("rst_busy", busy, 0);
    chk("rst_cnt", xfer_cnt, 0);
    reset = 1'b0;

    // Full contention: 10,11,12,13 twice with rotating acks.
    repeat (8) step(4'hF, 1'b1);
    chk("cnt_after_8", xfer_cnt, 8);

    // Back-pressure lock on requester 0, then 23 from requester 2.
    data_arr[0] = 8'd21;
    data_arr[2] = 8'd23;
    repeat (3) step(4'b0101, 1'b0);
    step(4'b0101, 1'b1);
    step(4'b0100, 1'b1);

    // Stall on requester 1 then abandon.
    data_arr[1] = 8'd55;
    repeat (2) step(4'b0010, 1'b0);
    step(4'b0000, 1'b0);
    step(4'b0000, 1'b1);
    chk("cnt_after_abandon", xfer_cnt, 10);

    // Fill, stall, then reset mid-stall.
    for (int i = 0; i < N; i++) data_arr[i] = W'(11 + i);
    repeat (4) step(4'hF, 1'b1);
    repeat (2) step(4'hF, 1'b0);
    #2 reset = 1'b1;
    #1;
    chk("midrst_wr_en", fifo_wr_en, 0);
    chk("midrst_ack", req_ack, 0);
    chk("midrst_wr_data", fifo_wr_data, 0);
    chk("midrst_busy", busy, 0);
    chk("midrst_cnt", xfer_cnt, 0);
    model_reset();
    @(posedge clk);
    #1 reset = 1'b0;
    drive(4'hF, 1'b1);
    #1;
    chk("first_after_reset", req_ack, 4'b0001);
    step(4'hF, 1'b1);

    // 17 words total since reset: the 4-bit counter wraps to 1.
    repeat (16) step(4'hF, 1'b1);
    chk("cnt_w4_wrap", xfer_cnt4, 1);
    chk("cnt_17", xfer_cnt, 17);

`ifdef FIFO_ARB_BURST_LOCK_EN
    reset = 1'b1;
    model_reset();
    @(posedge clk);
    #1 reset = 1'b0;
    data_arr[0] = 8'd31; data_arr[1] = 8'd40;
    last_v = 4'b1110;
    step(4'b0011, 1'b1);
    data_arr[0] = 8'd32;
    step(4'b0011, 1'b0);
    step(4'b0011, 1'b1);
    data_arr[0] = 8'd33;
    last_v = 4'b1111;
    step(4'b0010, 1'b1);
    step(4'b0011, 1'b1);
    step(4'b0010, 1'b1);
    chk("burst_cnt", xfer_cnt, 4);
`endif

    // Random traffic obeying hold-until-ack, with occasional abandons.
    last_v = '1;
    pend   = '0;
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < N; i++) begin
        if (!pend[i] && $urandom_range(0, 1) == 1) begin
          pend[i]     = 1'b1;
          data_arr[i] = W'($urandom);
        end else if (pend[i] && $urandom_range(0, 39) == 0) begin
          pend[i] = 1'b0;
        end
      end
      step(pend, $urandom_range(0, 3) != 0);
      if (acked_idx >= 0) pend[IW'(acked_idx)] = 1'b0;
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
